// File: rtl/zn_fsk_uart_rx.sv
// zn_fsk_uart_rx: byte deframer for the demodulated FSK bit stream.
//
// Conditions the incoming bit (2-flop synchronizer, 3-tap majority filter),
// hunts for a start bit, samples each bit at mid-period and checks the frame
// (start, 8 data bits LSB first, optional even parity, stop). A good byte is
// presented on rx_data with a one-cycle rx_valid strobe.
//
// Optional feature macro: ZN_FSK_PARITY_EN (adds an even-parity bit after the
// data bits; when undefined, parity_err is tied to 0).
//
// Ports:
//   clk        in   system/sample clock
//   rst        in   asynchronous reset, active low
//   bit_in     in   demodulated serial bit, idle high
//   rx_data    out  last good byte, held until the next good byte
//   rx_valid   out  one-cycle pulse when rx_data was just updated
//   frame_err  out  one-cycle pulse when the stop bit samples 0
//   parity_err out  one-cycle pulse on a parity mismatch
//   busy       out  high whenever the deframer is not idle
module zn_fsk_uart_rx #(
    parameter int unsigned CLKS_PER_BIT = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       bit_in,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    output logic       frame_err,
    output logic       parity_err,
    output logic       busy
);

    localparam int unsigned CntW = $clog2(CLKS_PER_BIT);
    // START decides one cycle early because the IDLE detect cycle counts too.
    localparam logic [CntW-1:0] CntHalf = CntW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CntW-1:0] CntLast = CntW'(CLKS_PER_BIT - 1);

    typedef enum logic [2:0] {
        StIdle,
        StStart,
        StData,
`ifdef ZN_FSK_PARITY_EN
        StParity,
`endif
        StStop,
        StWaitHigh
    } state_e;

    // Input conditioning
    logic [1:0] r_sync;
    logic [2:0] r_taps;
    logic       r_filt;
    logic       w_maj;

    assign w_maj = (r_taps[0] & r_taps[1]) | (r_taps[0] & r_taps[2]) |
                   (r_taps[1] & r_taps[2]);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_sync <= 2'b11;
            r_taps <= 3'b111;
            r_filt <= 1'b1;
        end else begin
            r_sync <= {r_sync[0], bit_in};
            r_taps <= {r_taps[1:0], r_sync[1]};
            r_filt <= w_maj;
        end
    end

    // Deframer state
    state_e          r_state, w_state_next;
    logic [CntW-1:0] r_cnt, w_cnt_next;
    logic [2:0]      r_bit_idx, w_bit_idx_next;
    logic [7:0]      r_shift, w_shift_next;
    logic [7:0]      r_rx_data, w_rx_data_next;
    logic            r_rx_valid, w_rx_valid_next;
    logic            r_frame_err, w_frame_err_next;
`ifdef ZN_FSK_PARITY_EN
    logic            r_par_bad, w_par_bad_next;
    logic            r_parity_err, w_parity_err_next;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state      <= StIdle;
            r_cnt        <= '0;
            r_bit_idx    <= '0;
            r_shift      <= '0;
            r_rx_data    <= '0;
            r_rx_valid   <= 1'b0;
            r_frame_err  <= 1'b0;
`ifdef ZN_FSK_PARITY_EN
            r_par_bad    <= 1'b0;
            r_parity_err <= 1'b0;
`endif
        end else begin
            r_state      <= w_state_next;
            r_cnt        <= w_cnt_next;
            r_bit_idx    <= w_bit_idx_next;
            r_shift      <= w_shift_next;
            r_rx_data    <= w_rx_data_next;
            r_rx_valid   <= w_rx_valid_next;
            r_frame_err  <= w_frame_err_next;
`ifdef ZN_FSK_PARITY_EN
            r_par_bad    <= w_par_bad_next;
            r_parity_err <= w_parity_err_next;
`endif
        end
    end

    always_comb begin
        w_state_next      = r_state;
        w_cnt_next        = r_cnt + 1'b1;
        w_bit_idx_next    = r_bit_idx;
        w_shift_next      = r_shift;
        w_rx_data_next    = r_rx_data;
        w_rx_valid_next   = 1'b0;
        w_frame_err_next  = 1'b0;
`ifdef ZN_FSK_PARITY_EN
        w_par_bad_next    = r_par_bad;
        w_parity_err_next = 1'b0;
`endif
        unique case (r_state)
            StIdle: begin
                w_cnt_next = '0;
                if (!r_filt) begin
                    w_state_next = StStart;
                end
            end
            StStart: begin
                if (r_cnt == CntHalf) begin
                    w_cnt_next     = '0;
                    w_bit_idx_next = '0;
                    // Line back high at mid-start: false start, no flags.
                    w_state_next   = r_filt ? StIdle : StData;
                end
            end
            StData: begin
                if (r_cnt == CntLast) begin
                    w_cnt_next              = '0;
                    w_shift_next[r_bit_idx] = r_filt;
                    w_bit_idx_next          = r_bit_idx + 3'd1;
                    if (r_bit_idx == 3'd7) begin
`ifdef ZN_FSK_PARITY_EN
                        w_state_next = StParity;
`else
                        w_state_next = StStop;
`endif
                    end
                end
            end
`ifdef ZN_FSK_PARITY_EN
            StParity: begin
                if (r_cnt == CntLast) begin
                    w_cnt_next     = '0;
                    w_par_bad_next = ^{r_shift, r_filt};
                    w_state_next   = StStop;
                end
            end
`endif
            StStop: begin
                if (r_cnt == CntLast) begin
                    w_cnt_next = '0;
                    if (r_filt) begin
                        w_state_next = StIdle;
`ifdef ZN_FSK_PARITY_EN
                        if (r_par_bad) begin
                            w_parity_err_next = 1'b1;
                        end else begin
                            w_rx_data_next  = r_shift;
                            w_rx_valid_next = 1'b1;
                        end
`else
                        w_rx_data_next  = r_shift;
                        w_rx_valid_next = 1'b1;
`endif
                    end else begin
                        // Stop low: flag once, then park until the line recovers.
                        w_state_next     = StWaitHigh;
                        w_frame_err_next = 1'b1;
`ifdef ZN_FSK_PARITY_EN
                        w_parity_err_next = r_par_bad;
`endif
                    end
                end
            end
            StWaitHigh: begin
                w_cnt_next = '0;
                if (r_filt) begin
                    w_state_next = StIdle;
                end
            end
            default: begin
                w_state_next = StIdle;
            end
        endcase
    end

    assign rx_data   = r_rx_data;
    assign rx_valid  = r_rx_valid;
    assign frame_err = r_frame_err;
    assign busy      = (r_state != StIdle);
`ifdef ZN_FSK_PARITY_EN
    assign parity_err = r_parity_err;
`else
    assign parity_err = 1'b0;
`endif

endmodule

// File: tb/tb_zn_fsk_uart_rx.sv
// Directed bench for zn_fsk_uart_rx at 16 clocks per bit.
module tb_zn_fsk_uart_rx;

    localparam int unsigned Cpb = 16;
`ifdef ZN_FSK_PARITY_EN
    localparam int unsigned ValidLat = 173;
`else
    localparam int unsigned ValidLat = 157;
`endif

    logic       clk;
    logic       rst;
    logic       bit_in;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       frame_err;
    logic       parity_err;
    logic       busy;

    zn_fsk_uart_rx #(
        .CLKS_PER_BIT(Cpb)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .bit_in    (bit_in),
        .rx_data   (rx_data),
        .rx_valid  (rx_valid),
        .frame_err (frame_err),
        .parity_err(parity_err),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Event monitor, sampled on the falling edge.
    int         n_valid = 0;
    int         n_ferr  = 0;
    int         n_perr  = 0;
    int         n_both  = 0;
    int         n_busy  = 0;
    int         valid_at = 0;
    logic [7:0] got[$];

    always @(negedge clk) begin
        if (rx_valid) begin
            n_valid++;
            valid_at = cyc;
            got.push_back(rx_data);
        end
        if (frame_err) n_ferr++;
        if (parity_err) n_perr++;
        if (rx_valid && (frame_err || parity_err)) n_both++;
        if (busy) n_busy++;
    end

    int n_cmp  = 0;
    int n_fail = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic idle(input int n);
        bit_in = 1'b1;
        repeat (n) @(negedge clk);
    endtask

    // Call right after a falling edge; leaves the line at the stop level.
    task automatic send_frame(input logic [7:0] d, input logic stop_b);
        bit_in = 1'b0;
        repeat (Cpb) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            bit_in = d[i];
            repeat (Cpb) @(negedge clk);
        end
`ifdef ZN_FSK_PARITY_EN
        bit_in = ^d;
        repeat (Cpb) @(negedge clk);
`endif
        bit_in = stop_b;
        repeat (Cpb) @(negedge clk);
    endtask

`ifdef ZN_FSK_PARITY_EN
    task automatic send_frame_par(input logic [7:0] d, input logic pbit);
        bit_in = 1'b0;
        repeat (Cpb) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            bit_in = d[i];
            repeat (Cpb) @(negedge clk);
        end
        bit_in = pbit;
        repeat (Cpb) @(negedge clk);
        bit_in = 1'b1;
        repeat (Cpb) @(negedge clk);
    endtask
`endif

    int         t_start;
    int         v0;
    int         f0;
    int         p0;
    int         b0;
    logic [7:0] partial;

    initial begin
        rst    = 1'b0;
        bit_in = 1'b1;
        repeat (3) @(negedge clk);
        chk("reset rx_data", 32'(rx_data), 32'h00);
        chk("reset rx_valid", 32'(rx_valid), 32'h0);
        chk("reset frame_err", 32'(frame_err), 32'h0);
        chk("reset parity_err", 32'(parity_err), 32'h0);
        chk("reset busy", 32'(busy), 32'h0);
        rst = 1'b1;
        idle(20);
        chk("idle busy", 32'(busy), 32'h0);

        // Single frame 0xA5 with latency check.
        v0 = n_valid; f0 = n_ferr; p0 = n_perr;
        t_start = cyc + 1;
        send_frame(8'hA5, 1'b1);
        idle(30);
        chk("a5 valid count", 32'(n_valid - v0), 32'd1);
        chk("a5 valid cycle", 32'(valid_at - t_start), 32'(ValidLat));
        chk("a5 rx_data", 32'(rx_data), 32'hA5);
        chk("a5 frame_err", 32'(n_ferr - f0), 32'd0);
        chk("a5 parity_err", 32'(n_perr - p0), 32'd0);

        // Back-to-back frames with no idle gap.
        v0 = n_valid;
        send_frame(8'h00, 1'b1);
        send_frame(8'hFF, 1'b1);
        send_frame(8'h3C, 1'b1);
        idle(30);
        chk("b2b valid count", 32'(n_valid - v0), 32'd3);
        chk("b2b byte0", 32'(got[v0]), 32'h00);
        chk("b2b byte1", 32'(got[v0 + 1]), 32'hFF);
        chk("b2b byte2", 32'(got[v0 + 2]), 32'h3C);
        chk("b2b frame_err", 32'(n_ferr - f0), 32'd0);

        // One-cycle glitch is filtered out.
        b0 = n_busy;
        bit_in = 1'b0;
        @(negedge clk);
        idle(20);
        chk("glitch1 busy", 32'(n_busy - b0), 32'd0);

        // Six-cycle pulse: false start.
        b0 = n_busy; v0 = n_valid; f0 = n_ferr;
        bit_in = 1'b0;
        repeat (6) @(negedge clk);
        idle(40);
        chk("glitch6 busy seen", 32'(n_busy > b0), 32'd1);
        chk("glitch6 busy now", 32'(busy), 32'h0);
        chk("glitch6 valid", 32'(n_valid - v0), 32'd0);
        chk("glitch6 frame_err", 32'(n_ferr - f0), 32'd0);

        // Stop bit 0 followed by a 200-cycle break.
        v0 = n_valid; f0 = n_ferr;
        send_frame(8'h55, 1'b0);
        repeat (200) @(negedge clk);
        chk("break frame_err", 32'(n_ferr - f0), 32'd1);
        chk("break busy held", 32'(busy), 32'h1);
        chk("break rx_data", 32'(rx_data), 32'h3C);
        chk("break valid", 32'(n_valid - v0), 32'd0);
        idle(20);
        chk("break busy after", 32'(busy), 32'h0);
        chk("break frame_err total", 32'(n_ferr - f0), 32'd1);

`ifdef ZN_FSK_PARITY_EN
        v0 = n_valid; p0 = n_perr;
        send_frame_par(8'h07, 1'b1);
        idle(30);
        chk("par good valid", 32'(n_valid - v0), 32'd1);
        chk("par good rx_data", 32'(rx_data), 32'h07);
        chk("par good parity_err", 32'(n_perr - p0), 32'd0);
        v0 = n_valid;
        send_frame_par(8'h07, 1'b0);
        idle(30);
        chk("par bad parity_err", 32'(n_perr - p0), 32'd1);
        chk("par bad valid", 32'(n_valid - v0), 32'd0);
        chk("par bad rx_data", 32'(rx_data), 32'h07);
`endif

        // Reset asserted halfway through data bit 4.
        partial = 8'hC3;
        bit_in = 1'b0;
        repeat (Cpb) @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            bit_in = partial[i];
            repeat (Cpb) @(negedge clk);
        end
        bit_in = partial[4];
        repeat (Cpb / 2) @(negedge clk);
        chk("pre-reset busy", 32'(busy), 32'h1);
        rst = 1'b0;
        #1;
        chk("midrst rx_data", 32'(rx_data), 32'h00);
        chk("midrst rx_valid", 32'(rx_valid), 32'h0);
        chk("midrst frame_err", 32'(frame_err), 32'h0);
        chk("midrst parity_err", 32'(parity_err), 32'h0);
        chk("midrst busy", 32'(busy), 32'h0);
        bit_in = 1'b1;
        repeat (4) @(negedge clk);
        rst = 1'b1;
        idle(20);
        v0 = n_valid;
        send_frame(8'h81, 1'b1);
        idle(30);
        chk("post-reset valid", 32'(n_valid - v0), 32'd1);
        chk("post-reset rx_data", 32'(rx_data), 32'h81);

        chk("valid/error overlap", 32'(n_both), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
